// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO.
//   FIFO_NORMAL    : registered read; q updates on the edge that pops a word
//   FIFO_SHOWAHEAD : first-word-fall-through; q shows the head word
//   clog2()        : constant ceiling-log2 helper for sizing
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_NORMAL    = 32'sd0;
  localparam int FIFO_SHOWAHEAD = 32'sd1;

  // Smallest r such that 2**r >= value (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Producer/consumer bus of the synchronous FIFO.
//   data/wrreq        : write side (producer drives)
//   rdreq             : read request / head acknowledge (consumer drives)
//   q, usedw, flags   : read data, occupancy and status (FIFO drives)
// Modports: master = producer/consumer side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);

  logic [DATA_W-1:0] data;
  logic              wrreq;
  logic              rdreq;
  logic [DATA_W-1:0] q;
  logic [ADDR_W:0]   usedw;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_dpram.sv
// -----------------------------------------------------------------------------
// sfifo_dpram
// Simple dual-port RAM, DATA_W x 2**ADDR_W, registered write port.
//   i_clock, i_rst_n, i_srst : clock, async reset and sync clear (read register)
//   i_we, i_wr_addr, i_wr_data : write port
//   i_re, i_rd_addr           : read enable / address
//   o_rd_data                 : read data; registered (REG_RD=1) or
//                               asynchronous (REG_RD=0)
// Storage is not reset; only the optional read register is.
// -----------------------------------------------------------------------------
module sfifo_dpram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_RD = 1
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic              i_srst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  // Write port: storage array, intentionally without reset.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end else begin
      r_mem[i_wr_addr] <= r_mem[i_wr_addr];
    end
  end

  generate
    if (REG_RD != 32'sd0) begin : g_reg_rd
      logic [DATA_W-1:0] r_rd_data;

      // Registered read port: loads only when a read is accepted.
      always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rd_data <= {DATA_W{1'b0}};
        end else if (i_srst) begin
          r_rd_data <= {DATA_W{1'b0}};
        end else if (i_re) begin
          r_rd_data <= r_mem[i_rd_addr];
        end else begin
          r_rd_data <= r_rd_data;
        end
      end

      assign o_rd_data = r_rd_data;
    end else begin : g_async_rd
      assign o_rd_data = r_mem[i_rd_addr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with normal or show-ahead read mode,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clock : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sclr  : synchronous clear, priority over wrreq/rdreq
//   bus   : sync_fifo_param_if.slave (data, wrreq, rdreq, q, usedw, flags)
// All status outputs are registered from the next-state occupancy.
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int AF_TH      = 254,
  parameter int AE_TH      = 2,
  parameter int SHOW_AHEAD = FIFO_NORMAL
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 sclr,
  sync_fifo_param_if.slave     bus
);

  localparam int                DEPTH       = 32'sd1 << ADDR_W;
  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_AF_TH    = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0]   LP_AE_TH    = (ADDR_W+1)'(AE_TH);
  localparam logic [ADDR_W:0]   LP_CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE  = ADDR_W'(1);

  generate
    if ((AF_TH < 32'sd1) || (AF_TH > DEPTH)) begin : g_bad_af_th
      $error("sync_fifo_param: AF_TH=%0d outside 1..%0d", AF_TH, DEPTH);
    end
    if ((AE_TH < 32'sd1) || (AE_TH > DEPTH)) begin : g_bad_ae_th
      $error("sync_fifo_param: AE_TH=%0d outside 1..%0d", AE_TH, DEPTH);
    end
  endgenerate

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_usedw;
  logic              r_empty;
  logic              r_full;
  logic              r_almost_empty;
  logic              r_almost_full;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [ADDR_W:0]   w_usedw_nxt;
  logic [DATA_W-1:0] w_ram_q;

  // Accept decisions use the registered flags from before the edge, so a
  // full FIFO rejects the write even when a read frees a slot this cycle.
  assign w_wr_ok = bus.wrreq & ~r_full;
  assign w_rd_ok = bus.rdreq & ~r_empty;

  // Next-state occupancy from the accepted write/read pair.
  always_comb begin
    w_usedw_nxt = r_usedw;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_usedw_nxt = r_usedw + LP_CNT_ONE;
      2'b01:   w_usedw_nxt = r_usedw - LP_CNT_ONE;
      2'b11:   w_usedw_nxt = r_usedw;
      2'b00:   w_usedw_nxt = r_usedw;
      default: w_usedw_nxt = r_usedw;
    endcase
  end

  // Pointers, occupancy, status flags and sticky error flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= LP_PTR_ZERO;
      r_rd_ptr       <= LP_PTR_ZERO;
      r_usedw        <= LP_CNT_ZERO;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else if (sclr) begin
      r_wr_ptr       <= LP_PTR_ZERO;
      r_rd_ptr       <= LP_PTR_ZERO;
      r_usedw        <= LP_CNT_ZERO;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_usedw        <= w_usedw_nxt;
      r_empty        <= (w_usedw_nxt == LP_CNT_ZERO);
      r_full         <= (w_usedw_nxt == LP_DEPTH);
      r_almost_empty <= (w_usedw_nxt < LP_AE_TH);
      r_almost_full  <= (w_usedw_nxt >= LP_AF_TH);
      if (bus.wrreq && r_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      if (bus.rdreq && r_empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_underflow <= r_underflow;
      end
    end
  end

  generate
    if (SHOW_AHEAD == FIFO_SHOWAHEAD) begin : g_show_ahead
      logic [DATA_W-1:0] r_q;

      // The RAM is read one slot ahead of the head, so the word that
      // becomes the head after a pop is already available before the edge.
      sfifo_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_RD (32'sd0)
      ) u_ram (
        .i_clock   (clock),
        .i_rst_n   (rst_n),
        .i_srst    (sclr),
        .i_we      (w_wr_ok & ~sclr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data),
        .i_re      (w_rd_ok),
        .i_rd_addr (r_rd_ptr + LP_PTR_ONE),
        .o_rd_data (w_ram_q)
      );

      // Registered head word. The incoming write data becomes the head when
      // the FIFO was empty, or when the only stored word is popped while a
      // new one is written (that slot is not in the RAM yet).
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= {DATA_W{1'b0}};
        end else if (sclr) begin
          r_q <= {DATA_W{1'b0}};
        end else if (w_usedw_nxt == LP_CNT_ZERO) begin
          r_q <= r_q;
        end else if ((r_usedw == LP_CNT_ZERO) || (w_rd_ok && (r_usedw == LP_CNT_ONE))) begin
          r_q <= bus.data;
        end else if (w_rd_ok) begin
          r_q <= w_ram_q;
        end else begin
          r_q <= r_q;
        end
      end

      assign bus.q = r_q;
    end else begin : g_normal
      sfifo_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_RD (32'sd1)
      ) u_ram (
        .i_clock   (clock),
        .i_rst_n   (rst_n),
        .i_srst    (sclr),
        .i_we      (w_wr_ok & ~sclr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data),
        .i_re      (w_rd_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
      );

      assign bus.q = w_ram_q;
    end
  endgenerate

  assign bus.usedw        = r_usedw;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO that replaces the fixed 16x256 vendor FIFO IP with portable RTL.
- Width, depth and almost-full/almost-empty thresholds are generic.
- Read mode is selectable: normal (registered) or show-ahead.
- Sticky overflow/underflow error flags are added.
- Sits between a data producer and consumer in the same clock domain, e.g. UART/ADC buffering.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W words
AF_TH, 254, almost_full asserts when usedw >= AF_TH (range 1..2**ADDR_W)
AE_TH, 2, almost_empty asserts when usedw < AE_TH (range 1..2**ADDR_W)
SHOW_AHEAD, 0, 0 = normal read mode, 1 = show-ahead (first-word-fall-through)

Ports:
clock  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear, active-high
data  in  DATA_W  write data
wrreq  in  1  write request
rdreq  in  1  read request / acknowledge
q  out  DATA_W  read data
usedw  out  ADDR_W+1  words stored, 0..2**ADDR_W (no wrap at full)
empty  out  1  usedw == 0
full  out  1  usedw == 2**ADDR_W
almost_empty  out  1  usedw < AE_TH
almost_full  out  1  usedw >= AF_TH
overflow  out  1  sticky: wrreq seen while full
underflow  out  1  sticky: rdreq seen while empty

Behaviour:
- Reset (rst_n=0, async) values:
  - wr_ptr=0, rd_ptr=0, usedw=0, q=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - Memory contents are not reset.
- Pointers are ADDR_W bits and wrap naturally from 2**ADDR_W-1 to 0. Occupancy is tracked by a separate ADDR_W+1-bit counter.
- Write accept: wr_ok = wrreq & ~full. Read accept: rd_ok = rdreq & ~empty. Both use the flag values registered before the edge.
- Full and simultaneous rdreq+wrreq: the read is accepted, the write is rejected and sets overflow. usedw decrements by 1.
- Empty and simultaneous rdreq+wrreq: the write is accepted, the read is rejected and sets underflow. usedw increments by 1.
- Neither full nor empty, both accepted: usedw unchanged, both pointers advance.
- All flags are registered and derived from next-state usedw, so they are valid on the same edge that updates usedw.
- Normal mode (SHOW_AHEAD=0):
  - q loads mem[rd_ptr] on the edge where rd_ok=1, so data is visible 1 cycle after rdreq.
  - q holds its value otherwise.
- Show-ahead mode (SHOW_AHEAD=1):
  - q continuously shows the head word whenever empty=0; rdreq acts as an acknowledge that pops the head.
  - A word written into an empty FIFO at edge N appears on q and clears empty after edge N.
  - q is don't-care while empty, but the RTL drives the last value.
- Write-to-read latency: a written word is readable from the edge after the write in both modes.
- sclr: synchronous, priority over wrreq/rdreq in the same cycle.
  - Pointers, usedw and q go to 0; flags return to reset values; overflow/underflow clear.
- overflow/underflow: set on the edge of the offending request, held until sclr or rst_n.
- Reset asserted mid-burst: all state clears immediately (async); the first accepted write after release goes to address 0.
- Elaboration check: $error if AF_TH or AE_TH is outside 1..2**ADDR_W.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2;
  - localparam mode constants FIFO_NORMAL=0, FIFO_SHOWAHEAD=1.
- One sub-module, sfifo_dpram: simple dual-port RAM, DATA_W x 2**ADDR_W, with a registered write port.
  - Its read port is asynchronous for show-ahead, or registered with a read-enable for normal mode, selected by parameter.
- Control logic (pointers, counter, flags, sticky errors) lives in sync_fifo_param.

Test Plan:
- Defaults, normal mode; after reset write 0..255 with wrreq held 256 cycles:
  - full=1 and usedw=256 after the last edge;
  - almost_full rises when usedw reaches 254;
  - overflow stays 0.
- Continue from full:
  - one extra wrreq with data=16'hDEAD -> overflow=1 and usedw stays 256;
  - read all 256 -> q = 0,1,...,255, each 1 cycle after its rdreq;
  - empty=1 at end; almost_empty rises when usedw drops to 1.
- Empty FIFO: rdreq for 1 cycle -> underflow=1, usedw=0, q unchanged. Then sclr for 1 cycle -> underflow=0, overflow=0.
- At usedw=100, hold wrreq=rdreq=1 for 50 cycles -> usedw stays 100 and data order is preserved.
- SHOW_AHEAD=1, DATA_W=8, ADDR_W=4: write 8'hA5 at edge N -> q=8'hA5 and empty=0 after edge N, with no rdreq. One rdreq -> empty=1.
- Assert rst_n=0 mid-burst at usedw=37, asynchronously between clock edges -> all outputs reach reset values before the next edge. Writing 8 words after release reads back in order.
